rs_issue_queue: RTL and testbench
=================================

Name: rs_issue_queue

Overview:
- Reservation station feeding the ALU's RS-entry input. Dispatch writes decoded ops with source tags and values into it.
- Entries capture operands from the common data bus (CDB). The oldest fully-ready entry is selected and issued through a registered valid/ready output.
- Sits between dispatch/rename and alu1; produces the packed entry alu1 decodes via the `RS_* field macros.

Parameters:
- ENTRIES, 8, number of RS slots (power of 2, >=2).
- TAG_W, 5, ROB/physical tag width.
- XLEN, 32, operand width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all entries and the output register.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  at least one free slot.
- disp_op  in  7  opcode.
- disp_funct3  in  3  funct3.
- disp_src1_tag, disp_src2_tag  in  TAG_W  producer tags.
- disp_src1_rdy, disp_src2_rdy  in  1  operand already valid.
- disp_src1_val, disp_src2_val  in  XLEN  operand values (used when rdy).
- disp_imm  in  XLEN  sign-extended immediate.
- disp_dest_tag  in  TAG_W  destination tag.
- cdb_valid  in  1  result broadcast.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_value  in  XLEN  broadcast value.
- issue_valid  out  1  issue_entry holds a ready op.
- issue_ready  in  1  ALU accepts.
- issue_entry  out  `RS_WIDTH  packed {dest, imm, data2, data1, funct3, op} per `RS_* macros.

Behaviour:
- Reset (async, rst_n=0):
  - All entry valid bits, age counters and issue_valid are 0.
  - issue_entry is 0; disp_ready is 1 once reset is released.
- Entry state: valid, op, funct3, src1/src2 {rdy, tag, val}, imm, dest, age[$clog2(ENTRIES)-1:0].
- disp_ready is combinational on registered state only: any entry not valid. It does not depend on same-cycle issue freeing a slot.
- Allocate:
  - When disp_valid && disp_ready, write the lowest-index free slot at the clock edge with age=0.
  - Every other valid entry's age increments, saturating at ENTRIES-1.
- Dispatch/CDB bypass: if cdb_valid and a not-ready disp source tag == cdb_tag in the same cycle, the slot is written with rdy=1 and val=cdb_value.
- Wakeup:
  - On cdb_valid, every valid entry with srcN rdy=0 and tagN==cdb_tag sets rdy=1 and val=cdb_value at the edge.
  - Both sources may wake on the same broadcast.
- Select:
  - Eligible means valid with both rdy bits set in the current registered state.
  - Winner is the highest age; ties go to the lowest index.
- Output register:
  - Loads when !issue_valid || issue_ready. Loading clears the winner's valid bit at the same edge.
  - If there is no winner, issue_valid goes to 0 (when issue_ready) or stays at its held value.
  - While issue_valid && !issue_ready, issue_entry and issue_valid are held stable.
- Latency:
  - Dispatch with both sources ready → issue_valid high 2 cycles later.
  - CDB wakeup of the last operand → issue_valid high 2 cycles later (1 with the bypass feature).
- Full: disp_ready=0. A dispatch attempted while full is ignored; no state changes.
- Empty: no winner; the output drains.
- Simultaneous dispatch + issue in one cycle: both occur. The freed slot is not visible to disp_ready until the next cycle.
- Flush:
  - Clears all valid bits and issue_valid at the edge. Flush wins over dispatch, wakeup and issue in that cycle.
  - A held issue_entry is discarded.
- Reset mid-operation: immediately returns to the reset state; no partial issue.
- Arithmetic: no arithmetic on data; ages saturate and never wrap.

Optional Feature:
- Macro: RS_WAKEUP_BYPASS_EN.
- Defined:
  - An entry whose last missing operand(s) match this cycle's CDB is eligible for select in the same cycle.
  - The matching field in issue_entry takes cdb_value.
  - CDB-to-issue_valid latency is 1 cycle.
- Undefined: select sees registered readiness only (2-cycle latency). The port list is identical in both builds.

Decomposition:
- Shared header/package holds:
  - `RS_WIDTH, `RS_OP, `RS_FUNCT3, `RS_DATA1, `RS_DATA2, `RS_IMM, `RS_DEST field ranges, common with alu1/alu2.
  - Opcode constants: OP_R=7'b0110011, OP_I=7'b0010011, OP_LUI=7'b0110111.
- One sub-module, rs_select: combinational oldest-ready picker (inputs eligible vector and ages; outputs one-hot grant and valid).

Test Plan:
- Reset, then dispatch add (op 0110011, f3 000, src1=5, src2=7 ready, dest 3) → issue_valid=1 two cycles later; DATA1=5, DATA2=7, DEST=3; the slot frees.
- Dispatch addi with src1 tag 9 not ready; CDB tag 9 value 0x10 next cycle → issue 2 cycles after the CDB (1 with RS_WAKEUP_BYPASS_EN) with DATA1=0x10, IMM intact.
- Fill all 8 slots with src tags pending → disp_ready=0; a 9th dispatch is ignored. One CDB wakes slot 2 → it issues and disp_ready returns 1 the cycle after the free.
- Two entries ready simultaneously (older in slot 5, younger in slot 1) with issue_ready=0 for 3 cycles → issue_entry is held stable; slot 5 issues first, slot 1 second.
- Dispatch with src2 tag == cdb_tag in the same cycle → the entry is captured ready and issues without a further broadcast.
- Flush asserted with 4 valid entries, issue_valid=1 and a concurrent dispatch → next cycle issue_valid=0, all slots free, the dispatched op is not stored.

Source files
------------

// File: rtl/rs_issue_queue_pkg.sv
// Shared definitions for the reservation station and the ALUs that consume
// its packed entry: field ranges of the issue word and opcode constants.
// Optional build macro: RS_WAKEUP_BYPASS_EN (consumed by rs_issue_queue).
// Packed issue word layout (LSB first): op, funct3, data1, data2, imm, dest.
// The ranges below assume XLEN=32 and TAG_W=5.

`ifndef RS_ISSUE_QUEUE_FIELDS
`define RS_ISSUE_QUEUE_FIELDS
`define RS_WIDTH  111
`define RS_OP     6:0
`define RS_FUNCT3 9:7
`define RS_DATA1  41:10
`define RS_DATA2  73:42
`define RS_IMM    105:74
`define RS_DEST   110:106
`endif

package rs_issue_queue_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    // Operand/tag widths the field ranges were laid out for.
    localparam int RS_XLEN  = 32;
    localparam int RS_TAG_W = 5;

endpackage

// File: rtl/rs_select.sv
// Oldest-ready picker: grants the eligible entry with the highest age,
// lowest index on equal ages. Purely combinational.

module rs_select #(
    parameter int ENTRIES = 8,
    parameter int AGE_W   = 3
) (
    input  logic [ENTRIES-1:0]            eligible,
    input  logic [ENTRIES-1:0][AGE_W-1:0] ages,
    output logic [ENTRIES-1:0]            grant,
    output logic                          grant_valid
);

    logic [AGE_W-1:0] best_age;

    // Ascending scan with a strict compare so equal ages keep the lower index.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        best_age    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (eligible[i] && (!grant_valid || (ages[i] > best_age))) begin
                grant       = '0;
                grant[i]    = 1'b1;
                grant_valid = 1'b1;
                best_age    = ages[i];
            end
        end
    end

endmodule

// File: rtl/rs_issue_queue.sv
// Reservation station: dispatch writes ops into free slots, the CDB wakes
// pending operands, and the oldest fully-ready entry is issued through a
// registered valid/ready output register.
// Optional build macro: RS_WAKEUP_BYPASS_EN -- lets an entry whose last
// missing operands arrive on this cycle's CDB be selected in the same cycle.

module rs_issue_queue
    import rs_issue_queue_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int TAG_W   = 5,
    parameter int XLEN    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 disp_valid,
    output logic                 disp_ready,
    input  logic [6:0]           disp_op,
    input  logic [2:0]           disp_funct3,
    input  logic [TAG_W-1:0]     disp_src1_tag,
    input  logic [TAG_W-1:0]     disp_src2_tag,
    input  logic                 disp_src1_rdy,
    input  logic                 disp_src2_rdy,
    input  logic [XLEN-1:0]      disp_src1_val,
    input  logic [XLEN-1:0]      disp_src2_val,
    input  logic [XLEN-1:0]      disp_imm,
    input  logic [TAG_W-1:0]     disp_dest_tag,
    input  logic                 cdb_valid,
    input  logic [TAG_W-1:0]     cdb_tag,
    input  logic [XLEN-1:0]      cdb_value,
    output logic                 issue_valid,
    input  logic                 issue_ready,
    output logic [`RS_WIDTH-1:0] issue_entry
);

    localparam int AGE_W = $clog2(ENTRIES);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(ENTRIES - 1);

    // Per-entry state
    logic [ENTRIES-1:0]            valid_q, valid_d;
    logic [ENTRIES-1:0]            s1_rdy_q, s1_rdy_d;
    logic [ENTRIES-1:0]            s2_rdy_q, s2_rdy_d;
    logic [ENTRIES-1:0][AGE_W-1:0] age_q, age_d;
    logic [6:0]                    op_q     [ENTRIES];
    logic [6:0]                    op_d     [ENTRIES];
    logic [2:0]                    f3_q     [ENTRIES];
    logic [2:0]                    f3_d     [ENTRIES];
    logic [TAG_W-1:0]              s1_tag_q [ENTRIES];
    logic [TAG_W-1:0]              s1_tag_d [ENTRIES];
    logic [TAG_W-1:0]              s2_tag_q [ENTRIES];
    logic [TAG_W-1:0]              s2_tag_d [ENTRIES];
    logic [XLEN-1:0]               s1_val_q [ENTRIES];
    logic [XLEN-1:0]               s1_val_d [ENTRIES];
    logic [XLEN-1:0]               s2_val_q [ENTRIES];
    logic [XLEN-1:0]               s2_val_d [ENTRIES];
    logic [XLEN-1:0]               imm_q    [ENTRIES];
    logic [XLEN-1:0]               imm_d    [ENTRIES];
    logic [TAG_W-1:0]              dest_q   [ENTRIES];
    logic [TAG_W-1:0]              dest_d   [ENTRIES];

    // Output register
    logic                 issue_valid_q, issue_valid_d;
    logic [`RS_WIDTH-1:0] issue_entry_q, issue_entry_d;

    logic [ENTRIES-1:0]   wake1, wake2, eligible, grant;
    logic                 grant_valid;
    logic [AGE_W-1:0]     alloc_idx;
    logic                 do_alloc, issue_load, disp_hit1, disp_hit2;
    logic [`RS_WIDTH-1:0] win_entry;

    // Free-slot status comes from registered state only; a slot freed by
    // this cycle's issue becomes visible next cycle.
    assign disp_ready = ~(&valid_q);
    assign do_alloc   = disp_valid && disp_ready;
    assign issue_load = !issue_valid_q || issue_ready;
    assign disp_hit1  = cdb_valid && !disp_src1_rdy && (disp_src1_tag == cdb_tag);
    assign disp_hit2  = cdb_valid && !disp_src2_rdy && (disp_src2_tag == cdb_tag);

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_wake
            assign wake1[gi] = cdb_valid && valid_q[gi] && !s1_rdy_q[gi] && (s1_tag_q[gi] == cdb_tag);
            assign wake2[gi] = cdb_valid && valid_q[gi] && !s2_rdy_q[gi] && (s2_tag_q[gi] == cdb_tag);
`ifdef RS_WAKEUP_BYPASS_EN
            assign eligible[gi] = valid_q[gi] && (s1_rdy_q[gi] || wake1[gi])
                                              && (s2_rdy_q[gi] || wake2[gi]);
`else
            assign eligible[gi] = valid_q[gi] && s1_rdy_q[gi] && s2_rdy_q[gi];
`endif
        end
    endgenerate

    rs_select #(
        .ENTRIES (ENTRIES),
        .AGE_W   (AGE_W)
    ) u_select (
        .eligible    (eligible),
        .ages        (age_q),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Lowest-index free slot (descending scan so the lowest index wins).
    always_comb begin
        alloc_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_idx = AGE_W'(i);
        end
    end

    // Assemble the packed issue word of the granted entry.
    always_comb begin
        win_entry = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (grant[i]) begin
                win_entry[`RS_OP]     = op_q[i];
                win_entry[`RS_FUNCT3] = f3_q[i];
                win_entry[`RS_DATA1]  = s1_val_q[i];
                win_entry[`RS_DATA2]  = s2_val_q[i];
                win_entry[`RS_IMM]    = imm_q[i];
                win_entry[`RS_DEST]   = dest_q[i];
`ifdef RS_WAKEUP_BYPASS_EN
                if (wake1[i]) win_entry[`RS_DATA1] = cdb_value;
                if (wake2[i]) win_entry[`RS_DATA2] = cdb_value;
`endif
            end
        end
    end

    // Entry next state: wakeup, aging, issue release, allocation; flush last.
    always_comb begin
        valid_d  = valid_q;
        s1_rdy_d = s1_rdy_q;
        s2_rdy_d = s2_rdy_q;
        age_d    = age_q;
        op_d     = op_q;
        f3_d     = f3_q;
        s1_tag_d = s1_tag_q;
        s2_tag_d = s2_tag_q;
        s1_val_d = s1_val_q;
        s2_val_d = s2_val_q;
        imm_d    = imm_q;
        dest_d   = dest_q;
        for (int i = 0; i < ENTRIES; i++) begin
            if (wake1[i]) begin
                s1_rdy_d[i] = 1'b1;
                s1_val_d[i] = cdb_value;
            end
            if (wake2[i]) begin
                s2_rdy_d[i] = 1'b1;
                s2_val_d[i] = cdb_value;
            end
            if (do_alloc && valid_q[i] && (age_q[i] != AGE_MAX)) age_d[i] = age_q[i] + 1'b1;
            if (issue_load && grant[i]) valid_d[i] = 1'b0;
        end
        if (do_alloc) begin
            valid_d[alloc_idx]  = 1'b1;
            age_d[alloc_idx]    = '0;
            op_d[alloc_idx]     = disp_op;
            f3_d[alloc_idx]     = disp_funct3;
            s1_tag_d[alloc_idx] = disp_src1_tag;
            s2_tag_d[alloc_idx] = disp_src2_tag;
            s1_rdy_d[alloc_idx] = disp_src1_rdy || disp_hit1;
            s2_rdy_d[alloc_idx] = disp_src2_rdy || disp_hit2;
            s1_val_d[alloc_idx] = disp_hit1 ? cdb_value : disp_src1_val;
            s2_val_d[alloc_idx] = disp_hit2 ? cdb_value : disp_src2_val;
            imm_d[alloc_idx]    = disp_imm;
            dest_d[alloc_idx]   = disp_dest_tag;
        end
        if (flush) valid_d = '0;
    end

    // Output register: load when empty or accepted, hold under backpressure.
    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_entry_d = issue_entry_q;
        if (issue_load) begin
            issue_valid_d = grant_valid;
            if (grant_valid) issue_entry_d = win_entry;
        end
        if (flush) begin
            issue_valid_d = 1'b0;
            issue_entry_d = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
            s1_rdy_q      <= '0;
            s2_rdy_q      <= '0;
            age_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_entry_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                op_q[i]     <= '0;
                f3_q[i]     <= '0;
                s1_tag_q[i] <= '0;
                s2_tag_q[i] <= '0;
                s1_val_q[i] <= '0;
                s2_val_q[i] <= '0;
                imm_q[i]    <= '0;
                dest_q[i]   <= '0;
            end
        end else begin
            valid_q       <= valid_d;
            s1_rdy_q      <= s1_rdy_d;
            s2_rdy_q      <= s2_rdy_d;
            age_q         <= age_d;
            issue_valid_q <= issue_valid_d;
            issue_entry_q <= issue_entry_d;
            op_q          <= op_d;
            f3_q          <= f3_d;
            s1_tag_q      <= s1_tag_d;
            s2_tag_q      <= s2_tag_d;
            s1_val_q      <= s1_val_d;
            s2_val_q      <= s2_val_d;
            imm_q         <= imm_d;
            dest_q        <= dest_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_entry = issue_entry_q;

endmodule

// File: tb/tb_rs_issue_queue.sv
// Testbench for rs_issue_queue: directed table, hand-written corner
// sequences, then randomized traffic against a slot/age reference model.

module tb_rs_issue_queue;
    import rs_issue_queue_pkg::*;

`ifdef RS_WAKEUP_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n, flush, disp_valid, disp_ready;
    logic [6:0]   disp_op;
    logic [2:0]   disp_funct3;
    logic [4:0]   disp_src1_tag, disp_src2_tag, disp_dest_tag, cdb_tag;
    logic         disp_src1_rdy, disp_src2_rdy, cdb_valid, issue_valid, issue_ready;
    logic [31:0]  disp_src1_val, disp_src2_val, disp_imm, cdb_value;
    logic [110:0] issue_entry;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rs_issue_queue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_op(disp_op), .disp_funct3(disp_funct3),
        .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
        .disp_imm(disp_imm), .disp_dest_tag(disp_dest_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_entry(issue_entry)
    );

    // Issue word as laid out for the ALU: {dest, imm, data2, data1, funct3, op}
    function automatic logic [110:0] pk(logic [4:0] d, logic [31:0] imm, logic [31:0] v2,
                                        logic [31:0] v1, logic [2:0] f3, logic [6:0] op);
        return {d, imm, v2, v1, f3, op};
    endfunction

    task automatic chk(string nm, logic [110:0] act, logic [110:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic disp(logic [4:0] t1, logic r1, logic [4:0] t2, logic r2,
                        logic [31:0] v2, logic [4:0] dest);
        disp_valid = 1'b1; disp_op = OP_R; disp_funct3 = 3'd0;
        disp_src1_tag = t1; disp_src1_rdy = r1; disp_src1_val = 32'd0;
        disp_src2_tag = t2; disp_src2_rdy = r2; disp_src2_val = v2;
        disp_imm = 32'd0; disp_dest_tag = dest;
        step();
        disp_valid = 1'b0;
    endtask

    task automatic cdb(logic [4:0] t, logic [31:0] v);
        cdb_valid = 1'b1; cdb_tag = t; cdb_value = v;
        step();
        cdb_valid = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic dv; logic [6:0] op; logic [2:0] f3;
        logic [4:0] t1; logic r1; logic [31:0] v1;
        logic [4:0] t2; logic r2; logic [31:0] v2;
        logic [31:0] imm; logic [4:0] dest;
        logic cv; logic [4:0] ct; logic [31:0] cval; logic ir;
        logic e_iv; logic e_dr; logic e_chk; logic [110:0] e_ent;
    } vec_t;

    function automatic vec_t rw(logic dv, logic [6:0] op, logic [4:0] t1, logic r1, logic [31:0] v1,
                                logic [4:0] t2, logic r2, logic [31:0] v2, logic [31:0] imm,
                                logic [4:0] dest, logic cv, logic [4:0] ct, logic [31:0] cval,
                                logic e_iv, logic e_chk, logic [110:0] e_ent);
        vec_t r;
        r.dv = dv; r.op = op; r.f3 = 3'd0; r.t1 = t1; r.r1 = r1; r.v1 = v1;
        r.t2 = t2; r.r2 = r2; r.v2 = v2; r.imm = imm; r.dest = dest;
        r.cv = cv; r.ct = ct; r.cval = cval; r.ir = 1'b1;
        r.e_iv = e_iv; r.e_dr = 1'b1; r.e_chk = e_chk; r.e_ent = e_ent;
        return r;
    endfunction

    vec_t tbl[10];

    // ---------------- reference model ----------------
    // Slots hold the op contents; age is derived from how many allocations
    // happened after the op's own allocation, capped at N-1.
    logic         m_v[N], m_r1[N], m_r2[N];
    logic [6:0]   m_op[N];
    logic [2:0]   m_f3[N];
    logic [4:0]   m_t1[N], m_t2[N], m_dest[N];
    logic [31:0]  m_x1[N], m_x2[N], m_imm[N];
    int           m_seq[N];
    int           m_g;
    logic         m_iv;
    logic [110:0] m_ie;

    function automatic int m_age(int i);
        int a;
        a = m_g - m_seq[i];
        return (a > N - 1) ? N - 1 : a;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_v[i] = 1'b0;
        m_iv = 1'b0; m_ie = '0; m_g = 0;
    endtask

    function automatic logic m_any_free();
        for (int i = 0; i < N; i++) if (!m_v[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_step();
        int   free_i, win, best;
        logic h1[N], h2[N];
        if (flush) begin
            m_reset_keep_age();
            return;
        end
        free_i = -1;
        for (int i = 0; i < N; i++) if (!m_v[i] && free_i < 0) free_i = i;
        for (int i = 0; i < N; i++) begin
            h1[i] = cdb_valid && m_v[i] && !m_r1[i] && (m_t1[i] == cdb_tag);
            h2[i] = cdb_valid && m_v[i] && !m_r2[i] && (m_t2[i] == cdb_tag);
        end
        win = -1; best = -1;
        for (int i = 0; i < N; i++) begin
            if (m_v[i] && (m_r1[i] || (BYP && h1[i])) && (m_r2[i] || (BYP && h2[i])) && m_age(i) > best) begin
                best = m_age(i); win = i;
            end
        end
        if (!m_iv || issue_ready) begin
            if (win >= 0) begin
                m_iv = 1'b1;
                m_ie = pk(m_dest[win], m_imm[win], h2[win] ? cdb_value : m_x2[win],
                          h1[win] ? cdb_value : m_x1[win], m_f3[win], m_op[win]);
                m_v[win] = 1'b0;
            end else begin
                m_iv = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (h1[i]) begin m_r1[i] = 1'b1; m_x1[i] = cdb_value; end
            if (h2[i]) begin m_r2[i] = 1'b1; m_x2[i] = cdb_value; end
        end
        if (disp_valid && free_i >= 0) begin
            m_v[free_i] = 1'b1; m_op[free_i] = disp_op; m_f3[free_i] = disp_funct3;
            m_t1[free_i] = disp_src1_tag; m_t2[free_i] = disp_src2_tag;
            m_r1[free_i] = disp_src1_rdy || (cdb_valid && disp_src1_tag == cdb_tag);
            m_r2[free_i] = disp_src2_rdy || (cdb_valid && disp_src2_tag == cdb_tag);
            m_x1[free_i] = (!disp_src1_rdy && cdb_valid && disp_src1_tag == cdb_tag) ? cdb_value : disp_src1_val;
            m_x2[free_i] = (!disp_src2_rdy && cdb_valid && disp_src2_tag == cdb_tag) ? cdb_value : disp_src2_val;
            m_imm[free_i] = disp_imm; m_dest[free_i] = disp_dest_tag;
            m_g++;
            m_seq[free_i] = m_g;
        end
    endtask

    task automatic m_reset_keep_age();
        for (int i = 0; i < N; i++) m_v[i] = 1'b0;
        m_iv = 1'b0; m_ie = '0;
    endtask

    initial begin
        rst_n = 1'b0; issue_ready = 1'b1;
        disp_op = '0; disp_funct3 = '0; disp_src1_tag = '0; disp_src2_tag = '0;
        disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0; disp_src1_val = '0; disp_src2_val = '0;
        disp_imm = '0; disp_dest_tag = '0; cdb_tag = '0; cdb_value = '0;
        idle();
        repeat (2) @(negedge clk);
        chk("reset_issue_valid", issue_valid, 1'b0);
        chk("reset_issue_entry", issue_entry, '0);
        rst_n = 1'b1;
        step();
        chk("reset_disp_ready", disp_ready, 1'b1);

        // add; addi woken by CDB; dispatch-time CDB capture
        tbl[0] = rw(1, OP_R, 1, 1, 5, 2, 1, 7, 0, 3, 0, 0, 0, 0, 0, '0);
        tbl[1] = rw(0, OP_R, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, pk(3, 0, 7, 5, 0, OP_R));
        tbl[2] = rw(0, OP_R, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        tbl[3] = rw(1, OP_I, 9, 0, 0, 0, 1, 0, 32'h123, 4, 0, 0, 0, 0, 0, '0);
        tbl[4] = rw(0, OP_R, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h10, BYP, 1, pk(4, 32'h123, 0, 32'h10, 0, OP_I));
        tbl[5] = rw(0, OP_R, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, !BYP, 1, pk(4, 32'h123, 0, 32'h10, 0, OP_I));
        tbl[6] = rw(0, OP_R, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        tbl[7] = rw(1, OP_R, 1, 1, 32'h11, 12, 0, 32'hdead, 0, 6, 1, 12, 32'h22, 0, 0, '0);
        tbl[8] = rw(0, OP_R, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, pk(6, 0, 32'h22, 32'h11, 0, OP_R));
        tbl[9] = rw(0, OP_R, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);

        for (int k = 0; k < 10; k++) begin
            disp_valid = tbl[k].dv; disp_op = tbl[k].op; disp_funct3 = tbl[k].f3;
            disp_src1_tag = tbl[k].t1; disp_src1_rdy = tbl[k].r1; disp_src1_val = tbl[k].v1;
            disp_src2_tag = tbl[k].t2; disp_src2_rdy = tbl[k].r2; disp_src2_val = tbl[k].v2;
            disp_imm = tbl[k].imm; disp_dest_tag = tbl[k].dest;
            cdb_valid = tbl[k].cv; cdb_tag = tbl[k].ct; cdb_value = tbl[k].cval;
            issue_ready = tbl[k].ir;
            step();
            $display("vec %0d: issue_valid=%0b disp_ready=%0b entry=%h", k, issue_valid, disp_ready, issue_entry);
            chk("tbl_issue_valid", issue_valid, tbl[k].e_iv);
            chk("tbl_disp_ready", disp_ready, tbl[k].e_dr);
            if (tbl[k].e_chk && tbl[k].e_iv) chk("tbl_issue_entry", issue_entry, tbl[k].e_ent);
        end
        idle();

        // Fill all slots with pending ops, then a 9th dispatch
        for (int i = 0; i < N; i++) begin
            chk("fill_disp_ready", disp_ready, 1'b1);
            disp(5'(16 + i), 1'b0, 5'd0, 1'b1, 32'(i), 5'(i));
        end
        chk("full_disp_ready", disp_ready, 1'b0);
        disp(5'd30, 1'b0, 5'd0, 1'b1, 32'h99, 5'd31);
        chk("ninth_disp_ready", disp_ready, 1'b0);
        issue_ready = 1'b0;
        cdb(5'd18, 32'hAB);
        chk("wake2_issue_valid_t1", issue_valid, BYP);
        chk("wake2_disp_ready_t1", disp_ready, BYP);
        step();
        chk("wake2_issue_valid", issue_valid, 1'b1);
        chk("wake2_disp_ready", disp_ready, 1'b1);
        chk("wake2_entry", issue_entry, pk(2, 0, 2, 32'hAB, 0, OP_R));
        issue_ready = 1'b1;
        step();
        chk("wake2_drained", issue_valid, 1'b0);
        cdb(5'd30, 32'h5);
        step(); step();
        chk("ninth_ignored", issue_valid, 1'b0);

        // Flush with pending entries, a held issue and a concurrent dispatch
        issue_ready = 1'b0;
        cdb(5'd16, 32'h66);
        step();
        chk("preflush_issue_valid", issue_valid, 1'b1);
        chk("preflush_entry", issue_entry, pk(0, 0, 0, 32'h66, 0, OP_R));
        flush = 1'b1;
        disp(5'd1, 1'b1, 5'd2, 1'b1, 32'h9, 5'd9);
        flush = 1'b0;
        chk("flush_issue_valid", issue_valid, 1'b0);
        chk("flush_disp_ready", disp_ready, 1'b1);
        chk("flush_entry", issue_entry, '0);
        issue_ready = 1'b1;
        for (int t = 16; t < 24; t++) begin
            cdb(5'(t), 32'h1);
            chk("postflush_issue_valid", issue_valid, 1'b0);
        end
        step();
        chk("postflush_issue_valid", issue_valid, 1'b0);

        // Older slot 5 and younger slot 1 become ready on one broadcast
        for (int i = 0; i < 6; i++) disp(5'(20 + i), 1'b0, 5'd0, 1'b1, 32'(i), 5'(i));
        cdb(5'd21, 32'h3);
        step(); step();
        chk("slot1_drained", issue_valid, 1'b0);
        disp(5'd25, 1'b0, 5'd0, 1'b1, 32'h55, 5'd11);
        issue_ready = 1'b0;
        cdb(5'd25, 32'h77);
        step();
        for (int c = 0; c < 3; c++) begin
            chk("hold_issue_valid", issue_valid, 1'b1);
            chk("hold_entry", issue_entry, pk(5, 0, 5, 32'h77, 0, OP_R));
            step();
        end
        issue_ready = 1'b1;
        step();
        chk("second_issue_valid", issue_valid, 1'b1);
        chk("second_entry", issue_entry, pk(11, 0, 32'h55, 32'h77, 0, OP_R));
        step();
        chk("after_second", issue_valid, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;

        // Randomized traffic against the reference model
        m_reset();
        for (int k = 0; k < 1500; k++) begin
            chk("rand_issue_valid", issue_valid, m_iv);
            chk("rand_disp_ready", disp_ready, m_any_free());
            chk("rand_issue_entry", issue_entry, m_ie);
            if (k == 800) begin
                idle();
                rst_n = 1'b0;
                #1;
                chk("midreset_issue_valid", issue_valid, 1'b0);
                chk("midreset_disp_ready", disp_ready, 1'b1);
                chk("midreset_entry", issue_entry, '0);
                m_reset();
                step();
                rst_n = 1'b1;
            end
            disp_valid    = ($urandom_range(99) < 60);
            disp_op       = 7'($urandom);
            disp_funct3   = 3'($urandom);
            disp_src1_tag = 5'($urandom_range(7));
            disp_src2_tag = 5'($urandom_range(7));
            disp_src1_rdy = ($urandom_range(99) < 40);
            disp_src2_rdy = ($urandom_range(99) < 40);
            disp_src1_val = $urandom;
            disp_src2_val = $urandom;
            disp_imm      = $urandom;
            disp_dest_tag = 5'($urandom);
            cdb_valid     = ($urandom_range(99) < 50);
            cdb_tag       = 5'($urandom_range(7));
            cdb_value     = $urandom;
            issue_ready   = ($urandom_range(99) < 70);
            flush         = ($urandom_range(59) == 0);
            m_step();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
